cnn_layer_accel_awe_result_collector: RTL and testbench

- Receive end of the AWE DSP cascade: consumes the final dataout_valid / dataout_p / dataout_c stream leaving the last CE DSP of an AWE.
- Accumulates a configurable number of partial sums per output pixel, then scales, saturates and buffers each result.
- Presents results to the output write path over a valid/ready handshake.
- Raises a stall hint upstream, because the DSP chain cannot be back-pressured.

---
 rtl/cnn_layer_accel_awe_result_collector.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cnn_layer_accel_awe_result_collector.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_awe_result_collector.sv
// AWE result collector: the receive end of the AWE DSP cascade.
// It sums a configurable number of partial sums into each output pixel, then
// shifts and saturates the sum. Results go into a first-word-fall-through FIFO
// and leave over a valid/ready handshake. The DSP chain cannot be held off, so
// stall_req is raised when the FIFO gets close to full.
// Optional build macro: CNN_LAYER_ACCEL_RESULT_RELU_EN adds a relu_en input,
// latched on new_map, that clamps negative shifted values to zero.
module cnn_layer_accel_awe_result_collector #(
    parameter int C_P_OUTPUT_WIDTH = 48,
    parameter int C_ACCUM_WIDTH    = 56,
    parameter int C_RESULT_WIDTH   = 16,
    parameter int C_FIFO_DEPTH     = 16,
    parameter int C_AFULL_THRESH   = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        new_map,
    input  logic [7:0]                  num_partials,
    input  logic [15:0]                 num_outputs,
    input  logic [5:0]                  frac_shift,
`ifdef CNN_LAYER_ACCEL_RESULT_RELU_EN
    input  logic                        relu_en,
`endif
    input  logic                        dataout_valid,
    input  logic [C_P_OUTPUT_WIDTH-1:0] dataout_p,
    input  logic                        dataout_c,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [C_RESULT_WIDTH-1:0]   result_data,
    output logic                        stall_req,
    output logic                        map_done,
    output logic                        busy,
    output logic [2:0]                  err_flags
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int ACC = C_ACCUM_WIDTH;
    localparam int RW  = C_RESULT_WIDTH;

    typedef logic [AW:0] occ_t;
    localparam occ_t FIFO_FULL = occ_t'(C_FIFO_DEPTH);
    localparam occ_t AFULL_LVL = occ_t'(C_AFULL_THRESH);

    localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-RW+1){1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [ACC-1:0] SAT_MIN = {{(ACC-RW+1){1'b1}}, {(RW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Configuration latched on new_map
    logic [7:0]  num_partials_q, num_partials_d;
    logic [15:0] num_outputs_q,  num_outputs_d;
    logic [5:0]  frac_shift_q,   frac_shift_d;
    logic        relu_q,         relu_d;

    // Accumulation stage
    logic signed [ACC-1:0] acc_q, acc_d;
    logic [7:0]            part_cnt_q, part_cnt_d;
    logic                  close_q, close_d;

    // Shift / saturate stage
    logic signed [ACC-1:0] shifted_w;
    logic [RW-1:0]         sat_data_q, sat_data_d;
    logic                  sat_valid_q, sat_valid_d;
    logic [15:0]           out_cnt_q, out_cnt_d;

    // FIFO
    logic [RW-1:0] fifo_mem [C_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    occ_t          occ_q, occ_d;
    logic          push, push_ok, pop, fifo_full, last_push;

    logic          stall_q;
    logic [2:0]    err_q, err_d;

    logic signed [ACC-1:0] p_ext;

    assign p_ext = {{(ACC-C_P_OUTPUT_WIDTH){dataout_p[C_P_OUTPUT_WIDTH-1]}}, dataout_p};

    // A result in the saturate stage that is overtaken by new_map belongs to the
    // abandoned map and is discarded along with the partial group.
    assign push      = sat_valid_q && !new_map;
    assign pop       = result_valid && result_ready;
    assign fifo_full = (occ_q == FIFO_FULL);
    assign push_ok   = push && (!fifo_full || pop);
    assign last_push = push && (({1'b0, out_cnt_q} + 17'd1) == {1'b0, num_outputs_q});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; new_map always (re)starts a map
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (new_map) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (new_map)
                    state_d = ST_ACCUM;
                else if (num_outputs_q == 16'd0 || last_push)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = new_map ? ST_ACCUM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        map_done = (state_q == ST_DONE);
        busy     = (state_q != ST_IDLE);
    end

    // Configuration latch and partial-sum accumulation
    always_comb begin
        num_partials_d = num_partials_q;
        num_outputs_d  = num_outputs_q;
        frac_shift_d   = frac_shift_q;
        relu_d         = relu_q;
        acc_d          = acc_q;
        part_cnt_d     = part_cnt_q;
        close_d        = 1'b0;
        if (new_map) begin
            num_partials_d = (num_partials == 8'd0) ? 8'd1 : num_partials;
            num_outputs_d  = num_outputs;
            frac_shift_d   = frac_shift;
`ifdef CNN_LAYER_ACCEL_RESULT_RELU_EN
            relu_d         = relu_en;
`else
            relu_d         = 1'b0;
`endif
            part_cnt_d     = 8'd0;
        end else if (state_q == ST_ACCUM && dataout_valid) begin
            // First partial of a group loads, so no explicit clear is needed
            acc_d = (part_cnt_q == 8'd0) ? p_ext : acc_q + p_ext;
            if (part_cnt_q == num_partials_q - 8'd1) begin
                part_cnt_d = 8'd0;
                close_d    = 1'b1;
            end else begin
                part_cnt_d = part_cnt_q + 8'd1;
            end
        end
    end

    // Accumulator and configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            num_partials_q <= 8'd1;
            num_outputs_q  <= '0;
            frac_shift_q   <= '0;
            relu_q         <= 1'b0;
            acc_q          <= '0;
            part_cnt_q     <= '0;
            close_q        <= 1'b0;
        end else begin
            num_partials_q <= num_partials_d;
            num_outputs_q  <= num_outputs_d;
            frac_shift_q   <= frac_shift_d;
            relu_q         <= relu_d;
            acc_q          <= acc_d;
            part_cnt_q     <= part_cnt_d;
            close_q        <= close_d;
        end
    end

    // Arithmetic shift (floor), optional ReLU clamp, then saturation
    always_comb begin
        shifted_w = acc_q >>> frac_shift_q;
        if (relu_q && shifted_w[ACC-1])
            shifted_w = '0;
        if (shifted_w > SAT_MAX)
            sat_data_d = SAT_MAX[RW-1:0];
        else if (shifted_w < SAT_MIN)
            sat_data_d = SAT_MIN[RW-1:0];
        else
            sat_data_d = shifted_w[RW-1:0];
        sat_valid_d = close_q && !new_map;
        if (new_map)
            out_cnt_d = 16'd0;
        else if (push)
            out_cnt_d = out_cnt_q + 16'd1;
        else
            out_cnt_d = out_cnt_q;
    end

    // Saturate-stage pipeline registers and output counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_data_q  <= '0;
            sat_valid_q <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            sat_data_q  <= sat_data_d;
            sat_valid_q <= sat_valid_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    // FIFO storage; a dropped push never writes, so the head stays intact
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_q] <= sat_data_q;
    end

    // Occupancy next state
    always_comb begin
        occ_d = occ_q;
        if (push_ok && !pop)
            occ_d = occ_q + occ_t'(1);
        else if (!push_ok && pop)
            occ_d = occ_q - occ_t'(1);
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q <= occ_d;
        end
    end

    // Sticky error flags
    always_comb begin
        err_d = err_q;
        if (push && fifo_full && !pop)           err_d[0] = 1'b1;
        if (dataout_valid && dataout_c)          err_d[1] = 1'b1;
        if (dataout_valid && state_q == ST_IDLE) err_d[2] = 1'b1;
    end

    // Error and stall registers; stall follows last cycle's occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            err_q   <= err_d;
            stall_q <= (occ_q >= AFULL_LVL);
        end
    end

    // Output drive; data is forced to zero while the FIFO is empty
    always_comb begin
        result_valid = (occ_q != '0);
        result_data  = result_valid ? fifo_mem[rd_ptr_q] : '0;
        stall_req    = stall_q;
        err_flags    = err_q;
    end

endmodule

// File: tb/tb_cnn_layer_accel_awe_result_collector.sv
// Scoreboard bench for the AWE result collector.
module tb_cnn_layer_accel_awe_result_collector;

    localparam int PW = 48;
    localparam int RW = 16;
`ifdef CNN_LAYER_ACCEL_RESULT_RELU_EN
    localparam bit RELU_BUILD = 1'b1;
`else
    localparam bit RELU_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          new_map;
    logic [7:0]    num_partials;
    logic [15:0]   num_outputs;
    logic [5:0]    frac_shift;
`ifdef CNN_LAYER_ACCEL_RESULT_RELU_EN
    logic          relu_en;
`endif
    logic          dataout_valid;
    logic [PW-1:0] dataout_p;
    logic          dataout_c;
    logic          result_valid;
    logic          result_ready;
    logic [RW-1:0] result_data;
    logic          stall_req;
    logic          map_done;
    logic          busy;
    logic [2:0]    err_flags;

    int     vec_cnt = 0;
    int     err_cnt = 0;
    int     pop_cnt = 0;
    int     done_cnt = 0;
    bit     relu_cfg = 1'b0;
    longint sb_q[$];

    always #5 clk = ~clk;

    cnn_layer_accel_awe_result_collector dut (
        .clk           (clk),
        .rst           (rst),
        .new_map       (new_map),
        .num_partials  (num_partials),
        .num_outputs   (num_outputs),
        .frac_shift    (frac_shift),
`ifdef CNN_LAYER_ACCEL_RESULT_RELU_EN
        .relu_en       (relu_en),
`endif
        .dataout_valid (dataout_valid),
        .dataout_p     (dataout_p),
        .dataout_c     (dataout_c),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_data   (result_data),
        .stall_req     (stall_req),
        .map_done      (map_done),
        .busy          (busy),
        .err_flags     (err_flags)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model(input longint sum, input int fs, input bit relu);
        longint sh;
        sh = sum >>> fs;
        if (relu && RELU_BUILD && sh < 0) sh = 0;
        if (sh > 32767)  sh = 32767;
        if (sh < -32768) sh = -32768;
        return sh;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_map(input int np, input int no, input int fs, input bit relu);
        num_partials = 8'(np);
        num_outputs  = 16'(no);
        frac_shift   = 6'(fs);
        relu_cfg     = relu;
`ifdef CNN_LAYER_ACCEL_RESULT_RELU_EN
        relu_en      = relu;
`endif
        new_map = 1'b1;
        tick;
        new_map = 1'b0;
    endtask

    task automatic send(input longint p, input bit c);
        dataout_valid = 1'b1;
        dataout_p     = p[PW-1:0];
        dataout_c     = c;
        tick;
        dataout_valid = 1'b0;
        dataout_c     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (map_done) begin
                seen = 1'b1;
                break;
            end
            tick;
        end
        chk(tag, seen, 1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (sb_q.size() == 0 && !result_valid) break;
            tick;
        end
        chk(tag, sb_q.size(), 0);
    endtask

    // Output monitor: each accepted word is popped against the scoreboard
    always @(negedge clk) begin
        longint exp;
        if (!rst && result_valid && result_ready) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 99999;
            chk("result", $signed(result_data), exp);
            $display("pop %0d: data=%0d", pop_cnt, $signed(result_data));
            pop_cnt++;
        end
        if (!rst && map_done) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, p0;
        rst = 1'b1; new_map = 1'b0; num_partials = '0; num_outputs = '0; frac_shift = '0;
`ifdef CNN_LAYER_ACCEL_RESULT_RELU_EN
        relu_en = 1'b0;
`endif
        dataout_valid = 1'b0; dataout_p = '0; dataout_c = 1'b0; result_ready = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        chk("rst_valid", result_valid, 0);
        chk("rst_data", result_data, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_done", map_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_flags, 0);

        // Basic sum with exact latency of map_done / busy
        start_map(3, 1, 0, 0);
        chk("basic_busy", busy, 1);
        send(10, 0); send(-4, 0);
        sb_q.push_back(model(13, 0, 0));
        send(7, 0);
        tick; tick;
        chk("basic_valid", result_valid, 1);
        chk("basic_done", map_done, 1);
        tick;
        chk("basic_done_off", map_done, 0);
        chk("basic_idle", busy, 0);
        drain("basic_drain");

        // Shift, saturation and floor rounding, back to back
        start_map(1, 4, 4, 0);
        sb_q.push_back(model(64'sh100000, 4, 0));  send(64'sh100000, 0);
        sb_q.push_back(model(-64'sh100000, 4, 0)); send(-64'sh100000, 0);
        sb_q.push_back(model(64'sh50, 4, 0));      send(64'sh50, 0);
        sb_q.push_back(model(-64'sh51, 4, 0));     send(-64'sh51, 0);
        wait_done("shift_done");
        drain("shift_drain");

        // num_partials = 0 acts as 1
        start_map(0, 1, 0, 0);
        sb_q.push_back(model(7, 0, 0)); send(7, 0);
        wait_done("np0_done");
        drain("np0_drain");

        // num_outputs = 0 finishes on the next cycle
        start_map(1, 0, 0, 0);
        tick;
        chk("no0_done", map_done, 1);
        tick;
        chk("no0_idle", busy, 0);

        // Backpressure, stall and overflow
        result_ready = 1'b0;
        p0 = pop_cnt;
        start_map(1, 20, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            if (i <= 16) sb_q.push_back(model(i * 3 + 1, 0, 0));
            send(i * 3 + 1, 0);
            chk($sformatf("stall_%0d", i), stall_req, (i >= 15) ? 1 : 0);
        end
        wait_done("bp_done");
        chk("bp_overflow", err_flags[0], 1);
        chk("bp_valid", result_valid, 1);
        chk("bp_hold", $signed(result_data), sb_q[0]);
        tick;
        chk("bp_hold2", $signed(result_data), sb_q[0]);
        result_ready = 1'b1;
        drain("bp_drain");
        chk("bp_pops", pop_cnt - p0, 16);
        tick;
        chk("bp_stall_off", stall_req, 0);

        // Mid-map restart
        d0 = done_cnt;
        start_map(4, 1, 0, 0);
        send(5, 0); send(6, 0);
        start_map(2, 1, 0, 0);
        send(1, 0);
        sb_q.push_back(model(3, 0, 0));
        send(2, 0);
        wait_done("restart_done");
        tick;
        chk("restart_done_cnt", done_cnt - d0, 1);
        drain("restart_drain");

        // Error flags
        send(5, 0);
        chk("err_idle", err_flags, 3'b101);
        start_map(2, 1, 0, 0);
        send(4, 1);
        sb_q.push_back(model(10, 0, 0));
        send(6, 0);
        wait_done("carry_done");
        drain("carry_drain");
        chk("err_sticky", err_flags, 3'b111);

        // Reset in the middle of accumulation with data held in the FIFO
        result_ready = 1'b0;
        start_map(1, 5, 0, 0);
        send(1, 0); send(2, 0); send(3, 0);
        tick; tick;
        chk("pre_rst_valid", result_valid, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sb_q.delete();
        chk("mrst_valid", result_valid, 0);
        chk("mrst_data", result_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_err", err_flags, 0);
        chk("mrst_stall", stall_req, 0);
        result_ready = 1'b1;
        tick; tick;
        chk("mrst_empty", result_valid, 0);

        // ReLU (clamps only in the ReLU build)
        start_map(2, 1, 0, 1);
        send(-30, 0);
        sb_q.push_back(model(-50, 0, 1));
        send(-20, 0);
        wait_done("relu1_done");
        drain("relu1_drain");
        start_map(2, 1, 0, 0);
        send(-30, 0);
        sb_q.push_back(model(-50, 0, 0));
        send(-20, 0);
        wait_done("relu0_done");
        drain("relu0_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
